// File: rtl/tetris_note_sequencer.sv
// -----------------------------------------------------------------------------
// tetris_note_sequencer
//
// Walks an external synchronous note ROM (1-cycle read latency) and plays each
// entry as a square wave. Every entry sets a half-period and a duration. The
// duration is given in units, and each unit is tempo_scale ticks long. After
// each played note the output stays silent for GAP_TICKS ticks. Notes with a
// duration of zero are skipped, and no gap follows them. A half-period of zero
// is a rest: the note keeps its full length but the output stays silent.
//
// Ports
//   ACLK, ARESETN   clock, asynchronous active-low reset
//   ctrl_start      1-cycle pulse: start from note 0. Ignored while busy.
//   ctrl_stop       1-cycle pulse: abort to IDLE. Wins over ctrl_start.
//   ctrl_loop       level: wrap to note 0 after the last note
//   song_len        index of the last note
//   tempo_scale     ticks per duration unit (0 behaves as 1)
//   rom_addr        registered ROM address
//   rom_data        {half_period[PERIOD_W-1:0], duration_units[7:0]}
//   tone_out        square-wave output (registered)
//   busy            high whenever the FSM is not in IDLE
//   note_idx        index of the current note
//   done_pulse      1-cycle pulse when a non-looping song ends
//   dbg_state       current FSM state, for observation only
//
// Control protocol: the ctrl_start and ctrl_stop pulses have no handshake.
// Each is acted on in the cycle where it is sampled high. No acknowledge is
// returned. The caller sees the effect on busy one cycle later.
//
// GAP_TICKS must be at least 1.
// -----------------------------------------------------------------------------
module tetris_note_sequencer #(
  parameter int NOTE_ADDR_W = 6,
  parameter int PERIOD_W    = 20,
  parameter int TICK_DIV    = 100000,
  parameter int GAP_TICKS   = 10
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic                   ctrl_start,
  input  logic                   ctrl_stop,
  input  logic                   ctrl_loop,
  input  logic [NOTE_ADDR_W-1:0] song_len,
  input  logic [7:0]             tempo_scale,
  output logic [NOTE_ADDR_W-1:0] rom_addr,
  input  logic [PERIOD_W+7:0]    rom_data,
  output logic                   tone_out,
  output logic                   busy,
  output logic [NOTE_ADDR_W-1:0] note_idx,
  output logic                   done_pulse,
  output logic [2:0]             dbg_state
);

  localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [15:0]       GAP_LAST  = 16'(GAP_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_PLAY  = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [NOTE_ADDR_W-1:0] idx_q, idx_d;
  logic [NOTE_ADDR_W-1:0] rom_addr_q;
  logic [PERIOD_W-1:0]    hp_q, hp_d;
  logic [PERIOD_W-1:0]    hp_cnt_q, hp_cnt_d;
  logic [15:0]            target_q, target_d;
  // Counts duration ticks in PLAY and gap ticks in GAP.
  logic [15:0]            dur_cnt_q, dur_cnt_d;
  logic [TICK_W-1:0]      tick_cnt_q, tick_cnt_d;
  logic                   tone_q, tone_d;
  logic                   busy_q;
  logic                   done_q, done_d;

  logic [PERIOD_W-1:0]    rom_hp;
  logic [7:0]             rom_dur;
  logic [7:0]             eff_scale;
  logic                   tick;

  // What follows the end of a note. This is used both after a gap and when
  // a zero-duration note is skipped.
  state_e                 adv_state;
  logic [NOTE_ADDR_W-1:0] adv_idx;
  logic                   adv_done;

  assign rom_hp    = rom_data[PERIOD_W+7:8];
  assign rom_dur   = rom_data[7:0];
  assign eff_scale = (tempo_scale == 8'd0) ? 8'd1 : tempo_scale;
  assign tick      = (tick_cnt_q == TICK_LAST);

  always_comb begin
    adv_state = S_FETCH;
    adv_idx   = idx_q + NOTE_ADDR_W'(1);
    adv_done  = 1'b0;
    if (idx_q == song_len) begin
      if (ctrl_loop) begin
        adv_idx = '0;
      end else begin
        adv_state = S_IDLE;
        adv_idx   = idx_q;
        adv_done  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    hp_d       = hp_q;
    hp_cnt_d   = hp_cnt_q;
    target_d   = target_q;
    dur_cnt_d  = dur_cnt_q;
    tick_cnt_d = tick_cnt_q;
    tone_d     = tone_q;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        tone_d = 1'b0;
        if (ctrl_start) begin
          state_d = S_FETCH;
          idx_d   = '0;
        end
      end

      S_FETCH: state_d = S_LOAD;

      S_LOAD: begin
        hp_d     = rom_hp;
        target_d = 16'(rom_dur) * 16'(eff_scale);
        if (rom_dur == 8'd0) begin
          state_d = adv_state;
          idx_d   = adv_idx;
          done_d  = adv_done;
        end else begin
          state_d    = S_PLAY;
          tick_cnt_d = '0;
          hp_cnt_d   = '0;
          dur_cnt_d  = '0;
          tone_d     = 1'b0;
        end
      end

      S_PLAY: begin
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
        if (hp_q == '0) begin
          tone_d = 1'b0;
        end else if (hp_cnt_q == hp_q - PERIOD_W'(1)) begin
          hp_cnt_d = '0;
          tone_d   = ~tone_q;
        end else begin
          hp_cnt_d = hp_cnt_q + PERIOD_W'(1);
        end
        if (tick) begin
          // The tick that takes the count to target ends the note.
          if (dur_cnt_q == target_q - 16'd1) begin
            state_d    = S_GAP;
            tone_d     = 1'b0;
            tick_cnt_d = '0;
            dur_cnt_d  = '0;
          end else begin
            dur_cnt_d = dur_cnt_q + 16'd1;
          end
        end
      end

      S_GAP: begin
        tone_d     = 1'b0;
        tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
        if (tick) begin
          if (dur_cnt_q == GAP_LAST) begin
            state_d = adv_state;
            idx_d   = adv_idx;
            done_d  = adv_done;
          end else begin
            dur_cnt_d = dur_cnt_q + 16'd1;
          end
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (ctrl_stop) begin
      state_d = S_IDLE;
      idx_d   = idx_q;
      tone_d  = 1'b0;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      rom_addr_q <= '0;
      hp_q       <= '0;
      hp_cnt_q   <= '0;
      target_q   <= '0;
      dur_cnt_q  <= '0;
      tick_cnt_q <= '0;
      tone_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      rom_addr_q <= idx_d;
      hp_q       <= hp_d;
      hp_cnt_q   <= hp_cnt_d;
      target_q   <= target_d;
      dur_cnt_q  <= dur_cnt_d;
      tick_cnt_q <= tick_cnt_d;
      tone_q     <= tone_d;
      busy_q     <= (state_d != S_IDLE);
      done_q     <= done_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign note_idx   = idx_q;
  assign tone_out   = tone_q;
  assign busy       = busy_q;
  assign done_pulse = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_tetris_note_sequencer.sv
// -----------------------------------------------------------------------------
// Bench for tetris_note_sequencer with TICK_DIV=4, GAP_TICKS=1, NOTE_ADDR_W=3,
// PERIOD_W=8. A synchronous ROM model feeds the DUT.
//
// The reference model builds the expected per-cycle waveform of
// {busy, done_pulse, tone_out, note_idx} for a whole song. It works directly
// from the note list. Each note spends 2 cycles in fetch/load. A played note
// then lasts dur*max(tempo,1)*TICK_DIV cycles, and its tone is
// floor(k/hp) mod 2. A gap of GAP_TICKS*TICK_DIV silent cycles follows.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tetris_note_sequencer;

  localparam int AW = 3;
  localparam int PW = 8;
  localparam int TD = 4;
  localparam int GT = 1;
  localparam int DW = PW + 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          ctrl_start = 1'b0;
  logic          ctrl_stop  = 1'b0;
  logic          ctrl_loop  = 1'b0;
  logic [AW-1:0] song_len   = '0;
  logic [7:0]    tempo_scale = 8'd1;
  logic [AW-1:0] rom_addr;
  logic [DW-1:0] rom_data = '0;
  logic          tone_out;
  logic          busy;
  logic [AW-1:0] note_idx;
  logic          done_pulse;
  logic [2:0]    dbg_state;

  tetris_note_sequencer #(
    .NOTE_ADDR_W(AW),
    .PERIOD_W   (PW),
    .TICK_DIV   (TD),
    .GAP_TICKS  (GT)
  ) dut (
    .ACLK       (clk),
    .ARESETN    (rst_n),
    .ctrl_start (ctrl_start),
    .ctrl_stop  (ctrl_stop),
    .ctrl_loop  (ctrl_loop),
    .song_len   (song_len),
    .tempo_scale(tempo_scale),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .tone_out   (tone_out),
    .busy       (busy),
    .note_idx   (note_idx),
    .done_pulse (done_pulse),
    .dbg_state  (dbg_state)
  );

  // Synchronous ROM, 1-cycle latency.
  logic [DW-1:0] rom [0:7];
  always @(posedge clk) rom_data <= rom[rom_addr];

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_mis = 0;
  logic [5:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [5:0] pk(input logic b, input logic d, input logic t, input int i);
    return {b, d, t, 3'(i)};
  endfunction

  // Reference model: expected cycle-by-cycle outputs from the first cycle
  // after the start pulse is taken until one cycle past done.
  task automatic build_expected(input int slen, input int tscale);
    int idx, scale, target, hp, dur;
    logic tn;
    exp_q.delete();
    scale = (tscale == 0) ? 1 : tscale;
    idx = 0;
    while (1'b1) begin
      exp_q.push_back(pk(1'b1, 1'b0, 1'b0, idx));
      exp_q.push_back(pk(1'b1, 1'b0, 1'b0, idx));
      hp  = int'(rom[idx][DW-1:8]);
      dur = int'(rom[idx][7:0]);
      if (dur != 0) begin
        target = dur * scale;
        for (int k = 0; k < target * TD; k++) begin
          tn = (hp == 0) ? 1'b0 : (((k / hp) % 2) == 1);
          exp_q.push_back(pk(1'b1, 1'b0, tn, idx));
        end
        for (int k = 0; k < GT * TD; k++) exp_q.push_back(pk(1'b1, 1'b0, 1'b0, idx));
      end
      if (idx == slen) break;
      idx++;
    end
    exp_q.push_back(pk(1'b0, 1'b1, 1'b0, idx));
    exp_q.push_back(pk(1'b0, 1'b0, 1'b0, idx));
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic pulse(input logic s, input logic p);
    ctrl_start = s;
    ctrl_stop  = p;
    @(negedge clk);
    ctrl_start = 1'b0;
    ctrl_stop  = 1'b0;
  endtask

  task automatic run_and_compare(input string tag);
    logic [5:0] e;
    int cyc;
    cyc = 0;
    pulse(1'b1, 1'b0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check($sformatf("%s_c%0d", tag, cyc), 32'({busy, done_pulse, tone_out, note_idx}), 32'(e));
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idx(input logic [AW-1:0] v, input int budget, input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (note_idx == v && busy) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check(name, 32'(ok), 32'd1);
  endtask

  function automatic logic [DW-1:0] note(input int hp, input int dur);
    return {PW'(hp), 8'(dur)};
  endfunction

  // ---------------- single-note table ----------------
  typedef struct {
    int hp;
    int dur;
    int tempo;
    int exp_busy;
    int exp_high;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n, high_n, done_n, slen, tsc;
    logic [AW-1:0] seen[$];
    logic ok;

    for (int i = 0; i < 8; i++) rom[i] = '0;

    vecs[0] = '{3, 1, 2, 14, 3};
    vecs[1] = '{0, 2, 1, 14, 0};
    vecs[2] = '{2, 3, 0, 18, 6};
    vecs[3] = '{2, 3, 1, 18, 6};
    vecs[4] = '{1, 1, 1, 10, 2};
    vecs[5] = '{5, 0, 3,  2, 0};
    vecs[6] = '{4, 2, 3, 30, 12};
    vecs[7] = '{7, 1, 1, 10, 0};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_state", 32'({busy, tone_out, done_pulse, note_idx, rom_addr}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: one-note songs, totals over a fixed window
    for (int v = 0; v < 8; v++) begin
      rom[0] = note(vecs[v].hp, vecs[v].dur);
      song_len = '0;
      tempo_scale = 8'(vecs[v].tempo);
      ctrl_loop = 1'b0;
      busy_n = 0; high_n = 0; done_n = 0;
      pulse(1'b1, 1'b0);
      for (int c = 0; c < 60; c++) begin
        busy_n += int'(busy);
        high_n += int'(tone_out);
        done_n += int'(done_pulse);
        @(negedge clk);
      end
      check($sformatf("tbl%0d_busy_cycles", v), 32'(busy_n), 32'(vecs[v].exp_busy));
      check($sformatf("tbl%0d_high_cycles", v), 32'(high_n), 32'(vecs[v].exp_high));
      check($sformatf("tbl%0d_done_count", v), 32'(done_n), 32'd1);
    end

    // Exact single-note timeline
    rom[0] = note(3, 1); tempo_scale = 8'd2; song_len = '0;
    build_expected(0, 2);
    run_and_compare("single");

    // Rest and skip
    rom[0] = note(0, 2); rom[1] = note(5, 0); rom[2] = note(2, 1);
    song_len = 3'd2; tempo_scale = 8'd1;
    build_expected(2, 1);
    run_and_compare("rest_skip");

    // Tempo 0 behaves as tempo 1
    rom[0] = note(2, 3); song_len = '0; tempo_scale = 8'd0;
    build_expected(0, 0);
    run_and_compare("tempo0");

    // Randomized songs against the model
    for (int r = 0; r < 12; r++) begin
      slen = $urandom_range(0, 3);
      tsc  = $urandom_range(0, 2);
      for (int i = 0; i < 8; i++) rom[i] = note($urandom_range(0, 5), $urandom_range(0, 3));
      song_len = 3'(slen);
      tempo_scale = 8'(tsc);
      build_expected(slen, tsc);
      run_and_compare($sformatf("rand%0d", r));
    end

    // Loop: 0,1,0,1 with no done, then clear loop during note 1
    rom[0] = note(1, 1); rom[1] = note(2, 1);
    song_len = 3'd1; tempo_scale = 8'd1; ctrl_loop = 1'b1;
    seen.delete(); done_n = 0;
    pulse(1'b1, 1'b0);
    for (int c = 0; c < 45; c++) begin
      if (seen.size() == 0 || seen[seen.size()-1] != note_idx) seen.push_back(note_idx);
      done_n += int'(done_pulse);
      @(negedge clk);
    end
    check("loop_idx_changes", 32'(seen.size() >= 4), 32'd1);
    for (int i = 0; i < 4; i++)
      check($sformatf("loop_idx%0d", i), (i < seen.size()) ? 32'(seen[i]) : 32'hffff, 32'(i % 2));
    check("loop_no_done", 32'(done_n), 32'd0);
    wait_idx(3'd1, 20, "loop_reach_idx1");
    ctrl_loop = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 30; c++) begin
      if (done_pulse) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("loop_exit_done", 32'(ok), 32'd1);
    check("loop_exit_state", 32'({busy, note_idx}), 32'({1'b0, 3'd1}));
    repeat (3) @(negedge clk);

    // Stop mid-PLAY
    rom[0] = note(1, 3); song_len = '0; tempo_scale = 8'd2;
    pulse(1'b1, 1'b0);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (tone_out) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("stop_tone_seen", 32'(ok), 32'd1);
    pulse(1'b0, 1'b1);
    check("stop_outputs", 32'({busy, tone_out, done_pulse}), 32'd0);
    done_n = 0;
    for (int c = 0; c < 30; c++) begin
      done_n += int'(done_pulse);
      @(negedge clk);
    end
    check("stop_no_done", 32'(done_n), 32'd0);

    // Start and stop together while idle
    pulse(1'b1, 1'b1);
    busy_n = 0;
    for (int c = 0; c < 6; c++) begin
      busy_n += int'(busy);
      @(negedge clk);
    end
    check("collision_stays_idle", 32'(busy_n), 32'd0);

    // Start while busy is ignored
    rom[0] = note(1, 1); rom[1] = note(1, 1); rom[2] = note(1, 1);
    song_len = 3'd2; tempo_scale = 8'd1;
    pulse(1'b1, 1'b0);
    wait_idx(3'd1, 30, "busy_reach_idx1");
    repeat (3) @(negedge clk);
    pulse(1'b1, 1'b0);
    check("start_while_busy", 32'({busy, note_idx}), 32'({1'b1, 3'd1}));
    pulse(1'b0, 1'b1);
    @(negedge clk);

    // Asynchronous reset during PLAY of note 1
    rom[0] = note(1, 1); rom[1] = note(1, 3);
    song_len = 3'd1; tempo_scale = 8'd1;
    pulse(1'b1, 1'b0);
    wait_idx(3'd1, 30, "rst_reach_idx1");
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check("async_reset", 32'({busy, tone_out, done_pulse, note_idx, rom_addr}), 32'd0);
    #197 check("reset_hold", 32'({busy, tone_out, done_pulse, note_idx, rom_addr}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_idle", 32'({busy, tone_out, done_pulse, note_idx, rom_addr}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule

// File: doc/tetris_note_sequencer.md
# tetris_note_sequencer

Plays the Tetris melody by stepping through an external note ROM and generating a square-wave tone with per-note duration and an inter-note gap. It sits between the AXI4-Lite register bank of the Tetris_Song peripheral, which supplies start/stop/loop/length/tempo, and the audio output pin, and it drives the ROM address. The block is purely a sequencer: it owns no bus interface and no song storage.

## Interface
Parameters:
- `NOTE_ADDR_W`, 6: ROM address width (up to 64 notes).
- `PERIOD_W`, 20: half-period field width, in ACLK cycles.
- `TICK_DIV`, 100000: ACLK cycles per duration tick (1 ms at 100 MHz).
- `GAP_TICKS`, 10: number of silent ticks after every played note.

Ports:
- `ACLK`  in  1  the single clock.
- `ARESETN`  in  1  asynchronous active-low reset.
- `ctrl_start`  in  1  one-cycle pulse that starts playback from index 0 when idle.
- `ctrl_stop`  in  1  one-cycle pulse that aborts playback.
- `ctrl_loop`  in  1  level; after the last note, wrap to index 0 instead of finishing.
- `song_len`  in  NOTE_ADDR_W  index of the last note.
- `tempo_scale`  in  8  ticks per duration unit; the value 0 is treated as 1.
- `rom_addr`  out  NOTE_ADDR_W  ROM address, registered.
- `rom_data`  in  PERIOD_W+8  note data: bits [PERIOD_W+7:8] are the half-period, bits [7:0] are the duration units. Half-period 0 means a rest.
- `tone_out`  out  1  square-wave audio output.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `note_idx`  out  NOTE_ADDR_W  index of the current note.
- `done_pulse`  out  1  one-cycle pulse when a non-looping song ends.

## Operation
- ROM is synchronous with 1-cycle read latency: data for `rom_addr` presented in cycle F is valid in cycle F+1.
- FSM states: IDLE, FETCH, LOAD, PLAY, GAP.
- **IDLE**: on `ctrl_start`, go to FETCH with `note_idx`=`rom_addr`=0.
- **FETCH**: `rom_addr` is stable; go to LOAD.
- **LOAD**: capture half-period (`hp`) and duration (`dur`).
  - If `dur`=0, skip the note: advance the index and go to FETCH, or take the end action if this is the last note. No gap is inserted.
  - Otherwise go to PLAY.
  - Compute the target tick count as `dur` × max(`tempo_scale`,1), a 16-bit unsigned product.
- **PLAY**:
  - The tick counter counts 0..TICK_DIV-1; at TICK_DIV-1 it emits a tick and the duration counter increments.
  - The half-period counter increments each cycle; at `hp`-1 it clears and `tone_out` toggles.
  - If `hp`=0, `tone_out` is held at 0.
  - When the duration counter reaches the target, go to GAP and force `tone_out` to 0.
- **GAP**: `tone_out` stays 0 for GAP_TICKS ticks. Then:
  - If `note_idx` != `song_len`, increment the index and go to FETCH.
  - Otherwise this is the end action: with `ctrl_loop`=1, set the index to 0 and go to FETCH; with `ctrl_loop`=0, go to IDLE and pulse `done_pulse`.
- Entering PLAY or GAP clears the tick counter; entering PLAY also clears the half-period and duration counters and sets `tone_out` to 0.
- `ctrl_stop` in any state: go to IDLE at the next edge, `tone_out`=0, no `done_pulse`.
- `ctrl_start` while busy is ignored. When `ctrl_start` and `ctrl_stop` are asserted in the same cycle, stop wins.
- `song_len`, `tempo_scale` and `ctrl_loop` are sampled live: `tempo_scale` at LOAD, `song_len` and `ctrl_loop` at the end decision.
- `note_idx` wraps naturally at 2^NOTE_ADDR_W-1 → 0 if `song_len` is the maximum value.

## Timing
- Reset values: `rom_addr`=0, `tone_out`=0, `busy`=0, `note_idx`=0, `done_pulse`=0, state IDLE, all counters 0.
- `ctrl_start` sampled at edge N puts the FSM in FETCH after N; it is in LOAD after N+1 and in PLAY after N+2. `busy` rises after edge N.
- Within PLAY, `tone_out` first toggles `hp` cycles after PLAY entry, then every `hp` cycles.
- PLAY lasts exactly target×TICK_DIV cycles; GAP lasts exactly GAP_TICKS×TICK_DIV cycles.
- Note-to-note overhead is 2 cycles (FETCH + LOAD).
- `done_pulse` is high for exactly the first IDLE cycle; `busy` falls in that same cycle.
- All outputs are registered; there is no combinational input-to-output path.

## Test plan
Unless stated otherwise: TICK_DIV=4, GAP_TICKS=1, NOTE_ADDR_W=3.
- **Reset**: assert `ARESETN`=0 for 200 ns, including during PLAY → all outputs are 0 asynchronously and stay in reset state until release.
- **Single note**: `song_len`=0, `tempo_scale`=2, ROM[0]={hp=3, dur=1}, pulse start →
  - `busy` rises 1 cycle later;
  - PLAY lasts 8 cycles, with `tone_out` toggling at PLAY cycles 3 and 6 (high for cycles 3–5);
  - GAP lasts 4 cycles low;
  - then `done_pulse`=1 for 1 cycle and `busy`=0.
- **Rest and skip**: ROM={hp=0,dur=2}, {hp=5,dur=0}, {hp=2,dur=1}, `song_len`=2, `tempo_scale`=1 →
  - note 0 is 8 cycles silent, followed by a 4-cycle gap;
  - note 1 is skipped with no gap;
  - note 2 toggles every 2 cycles for 4 cycles;
  - `note_idx` sequence is 0,1,2.
- **Loop**: `ctrl_loop`=1, `song_len`=1 → `note_idx` goes 0,1,0,1…, with no `done_pulse`. Clearing `ctrl_loop` during note 1 gives `done_pulse` after note 1's gap.
- **Stop and collision**:
  - `ctrl_stop` mid-PLAY → IDLE and `tone_out`=0 next cycle, no `done_pulse`.
  - `ctrl_start` and `ctrl_stop` in the same IDLE cycle → stays IDLE.
  - `ctrl_start` while busy → `note_idx` is unchanged.
- **Tempo 0**: `tempo_scale`=0, dur=3 → PLAY lasts 12 cycles, identical to `tempo_scale`=1.
